// File: rtl/refresh_sm.sv
// DRAM auto-refresh sequencer: one AUTO REFRESH per request,
// then a fixed NOP recovery window, chaining on its final cycle.
module refresh_sm #(
    parameter int WAIT_CYCLES = 9
) (
    input  logic clk,
    input  logic reset_n,
    input  logic Refresh_Signal,
    output logic CS,
    output logic RAS,
    output logic CAS,
    output logic WE
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REFRESH = 2'b01,
        WAIT    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cmd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd     = 4'b1111;
        case (state_q)
            IDLE: begin
                if (Refresh_Signal) state_d = REFRESH;
            end
            REFRESH: begin
                cmd     = 4'b0001;
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cmd = 4'b0111;
                // Only the last NOP cycle looks at the request
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = Refresh_Signal ? REFRESH : IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign {CS, RAS, CAS, WE} = cmd;

endmodule

// File: tb/tb_refresh_sm.sv
// Self-checking bench for refresh_sm: vector table, async reset
// sequence, and randomized run against a countdown model.
module tb_refresh_sm;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic req = 1'b0;
    logic cs0, ras0, cas0, we0;
    logic cs1, ras1, cas1, we1;

    int tests = 0;
    int fails = 0;

    refresh_sm #(.WAIT_CYCLES(9)) dut (
        .clk(clk), .reset_n(reset_n), .Refresh_Signal(req),
        .CS(cs0), .RAS(ras0), .CAS(cas0), .WE(we0)
    );

    refresh_sm #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .Refresh_Signal(req),
        .CS(cs1), .RAS(ras1), .CAS(cas1), .WE(we1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [3:0] cmd0();
        return {cs0, ras0, cas0, we0};
    endfunction

    function automatic logic [3:0] cmd1();
        return {cs1, ras1, cas1, we1};
    endfunction

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push(input logic r, input int n, input logic [3:0] e);
        for (int i = 0; i < n; i++) vecs.push_back('{r, e});
    endtask

    // Model: rem = cycles left in the current command window
    // (W+1 on the AUTO REFRESH cycle, down to 1 on the last NOP).
    function automatic int next_rem(input int rem, input logic r,
                                    input int w);
        if (rem == 0) return r ? w + 1 : 0;
        if (rem == 1) return r ? w + 1 : 0;
        return rem - 1;
    endfunction

    function automatic logic [3:0] exp_cmd(input int rem, input int w);
        if (rem == 0) return 4'b1111;
        if (rem == w + 1) return 4'b0001;
        return 4'b0111;
    endfunction

    int rem0, rem1, hold;

    initial begin
        // idle after reset
        push(0, 10, 4'b1111);
        // single refresh, request held 5 clocks
        push(1, 1, 4'b0001);
        push(1, 4, 4'b0111);
        push(0, 5, 4'b0111);
        push(0, 1, 4'b1111);
        // pulse sampled during 3rd WAIT cycle is ignored
        push(1, 1, 4'b0001);
        push(0, 3, 4'b0111);
        push(1, 1, 4'b0111);
        push(0, 5, 4'b0111);
        push(0, 1, 4'b1111);
        // pulse on last WAIT cycle chains straight to REFRESH
        push(1, 1, 4'b0001);
        push(0, 9, 4'b0111);
        push(1, 1, 4'b0001);
        push(0, 9, 4'b0111);
        push(0, 2, 4'b1111);
        // held 15 clocks: period of 10, then drain
        push(1, 1, 4'b0001);
        push(1, 9, 4'b0111);
        push(1, 1, 4'b0001);
        push(1, 4, 4'b0111);
        push(0, 5, 4'b0111);
        push(0, 2, 4'b1111);

        #12;
        check("reset_w9", cmd0(), 4'b1111);
        check("reset_w1", cmd1(), 4'b1111);
        @(negedge clk) reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk) req = vecs[i].req;
            @(posedge clk) #1;
            check($sformatf("vec%0d", i), cmd0(), vecs[i].exp);
        end

        // async reset in the middle of WAIT
        @(negedge clk) req = 1'b1;
        @(posedge clk) #1 check("ar_ref", cmd0(), 4'b0001);
        @(negedge clk) req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b0;
        #1 check("ar_immediate", cmd0(), 4'b1111);
        @(posedge clk) #1 check("ar_held", cmd0(), 4'b1111);
        @(negedge clk) begin
            reset_n = 1'b1;
            req = 1'b1;
        end
        @(posedge clk) #1 check("ar_fresh_ref", cmd0(), 4'b0001);
        @(negedge clk) req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk) #1;
            check($sformatf("ar_wait%0d", i), cmd0(), 4'b0111);
        end
        @(posedge clk) #1 check("ar_idle", cmd0(), 4'b1111);

        // randomized run, both parameterizations
        @(negedge clk) reset_n = 1'b0;
        #1 reset_n = 1'b1;
        rem0 = 0;
        rem1 = 0;
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) begin
                reset_n = 1'b0;
                #1;
                check("rnd_rst_w9", cmd0(), 4'b1111);
                check("rnd_rst_w1", cmd1(), 4'b1111);
                rem0 = 0;
                rem1 = 0;
                #1 reset_n = 1'b1;
            end
            if (hold == 0) begin
                req  = ($urandom_range(0, 2) == 0);
                hold = int'($urandom_range(1, 14));
            end
            hold--;
            @(posedge clk);
            rem0 = next_rem(rem0, req, 9);
            rem1 = next_rem(rem1, req, 1);
            #1;
            check("rnd_w9", cmd0(), exp_cmd(rem0, 9));
            check("rnd_w1", cmd1(), exp_cmd(rem1, 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
